// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage sitting directly in front of decode. It walks a
// sequential PC, issues requests to instruction memory over a valid/ready
// port, and collects the in-order responses as {pc, instr} pairs in a small
// buffer. Decode drains that buffer with a valid/ready handshake. A redirect
// from execute flushes the buffer, and any responses still in flight for
// the old path are discarded as they arrive.
//
// Ports
//   clk              rising-edge clock for all state
//   rst              synchronous, active-high reset
//   imem_req_valid   request valid toward instruction memory
//   imem_req_ready   memory accepts the request this cycle
//   imem_req_addr    request address (current fetch PC)
//   imem_resp_valid  response valid (in order, never back-pressured)
//   imem_resp_data   fetched instruction word
//   redirect_valid   single-cycle redirect pulse from execute
//   redirect_pc      redirect target (passed through even if misaligned)
//   instr_valid      buffer head valid toward decode
//   instr_ready      decode accepts the head
//   instr_out        head instruction word (0 when empty)
//   pc_out           PC of the head instruction (0 when empty)
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter int                    FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_resp_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]  pc_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]        DEPTH_SUM = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]      PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(32'd4);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ADDR_WIDTH-1:0]   fetch_pc_r;
  logic [CNT_W-1:0]        outstanding_r;
  logic [CNT_W-1:0]        outstanding_nxt_s;
  logic [CNT_W-1:0]        drop_cnt_r;
  logic [CNT_W-1:0]        drop_nxt_s;

  // Instruction buffer toward decode.
  logic [INSTR_WIDTH-1:0]  fifo_instr_r [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   fifo_pc_r    [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;

  // PCs of requests that are in flight, oldest at pcq_rd_r.
  logic [ADDR_WIDTH-1:0]   pcq_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        pcq_wr_r;
  logic [PTR_W-1:0]        pcq_rd_r;

  logic                    credit_s;
  logic                    req_valid_s;
  logic                    req_fire_s;
  logic                    resp_keep_s;
  logic                    head_valid_s;
  logic                    pop_s;
  logic                    full_s;

  // Credit counts in-flight requests as already occupying the buffer, so a
  // response can always be pushed without back-pressuring memory.
  assign credit_s     = ({1'b0, count_r} + {1'b0, outstanding_r}) < DEPTH_SUM;
  assign req_valid_s  = !rst && (state_r == ST_FETCH) && credit_s;
  assign req_fire_s   = req_valid_s && imem_req_ready;
  assign resp_keep_s  = imem_resp_valid && (state_r == ST_FETCH);
  assign head_valid_s = (count_r != CNT_ZERO);
  assign full_s       = (count_r == DEPTH_CNT);
  assign pop_s        = instr_valid && instr_ready;

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r;
  assign instr_valid    = !rst && head_valid_s;
  assign instr_out      = instr_valid ? fifo_instr_r[rd_ptr_r] : {INSTR_WIDTH{1'b0}};
  assign pc_out         = instr_valid ? fifo_pc_r[rd_ptr_r]    : {ADDR_WIDTH{1'b0}};

  // Outstanding-request count after this cycle's accept and response.
  always_comb begin
    outstanding_nxt_s = outstanding_r;
    case ({req_fire_s, imem_resp_valid})
      2'b10:   outstanding_nxt_s = outstanding_r + CNT_ONE;
      2'b01:   outstanding_nxt_s = outstanding_r - CNT_ONE;
      default: outstanding_nxt_s = outstanding_r;
    endcase
  end

  // Next-state logic: DRAIN discards stale responses until none remain.
  always_comb begin
    state_nxt_s = state_r;
    drop_nxt_s  = drop_cnt_r;
    case (state_r)
      ST_FETCH: begin
        state_nxt_s = ST_FETCH;
        drop_nxt_s  = drop_cnt_r;
      end
      ST_DRAIN: begin
        if (imem_resp_valid) begin
          drop_nxt_s = drop_cnt_r - CNT_ONE;
        end else begin
          drop_nxt_s = drop_cnt_r;
        end
        if (drop_nxt_s == CNT_ZERO) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_FETCH;
        drop_nxt_s  = CNT_ZERO;
      end
    endcase
    // Everything still in flight after this cycle belongs to the old path,
    // including a request accepted in the redirect cycle itself.
    if (redirect_valid) begin
      drop_nxt_s = outstanding_nxt_s;
      if (outstanding_nxt_s == CNT_ZERO) begin
        state_nxt_s = ST_FETCH;
      end else begin
        state_nxt_s = ST_DRAIN;
      end
    end else begin
      state_nxt_s = state_nxt_s;
      drop_nxt_s  = drop_nxt_s;
    end
  end

  // FSM state, counters and fetch PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_FETCH;
      drop_cnt_r    <= CNT_ZERO;
      outstanding_r <= CNT_ZERO;
      fetch_pc_r    <= RESET_PC;
    end else begin
      state_r       <= state_nxt_s;
      drop_cnt_r    <= drop_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      if (redirect_valid) begin
        fetch_pc_r <= redirect_pc;
      end else if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
    end
  end

  // Instruction buffer pointers and occupancy; a redirect flushes it and
  // swallows any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (redirect_valid) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (resp_keep_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({resp_keep_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Buffer storage: the kept response is paired with its oldest in-flight PC.
  always_ff @(posedge clk) begin
    if (resp_keep_s) begin
      fifo_instr_r[wr_ptr_r] <= imem_resp_data;
      fifo_pc_r[wr_ptr_r]    <= pcq_r[pcq_rd_r];
    end
  end

  // In-flight PC queue pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcq_wr_r <= PTR_ZERO;
      pcq_rd_r <= PTR_ZERO;
    end else if (redirect_valid) begin
      pcq_wr_r <= PTR_ZERO;
      pcq_rd_r <= PTR_ZERO;
    end else begin
      if (req_fire_s) begin
        pcq_wr_r <= pcq_wr_r + PTR_ONE;
      end else begin
        pcq_wr_r <= pcq_wr_r;
      end
      if (resp_keep_s) begin
        pcq_rd_r <= pcq_rd_r + PTR_ONE;
      end else begin
        pcq_rd_r <= pcq_rd_r;
      end
    end
  end

  // In-flight PC queue storage: record the address of each accepted request.
  always_ff @(posedge clk) begin
    if (req_fire_s) begin
      pcq_r[pcq_wr_r] <= fetch_pc_r;
    end
  end

  fetch_unit_checker #(
    .CNT_W (CNT_W)
  ) u_checker (
    .clk         (clk),
    .rst         (rst),
    .resp_valid  (imem_resp_valid),
    .outstanding (outstanding_r),
    .push        (resp_keep_s),
    .full        (full_s)
  );

endmodule

// ---------------------------------------------------------------------------
// fetch_unit_checker
//
// Protocol and internal-consistency properties for fetch_unit.
//
// Ports
//   clk          clock
//   rst          synchronous reset (properties disabled while high)
//   resp_valid   memory response valid
//   outstanding  requests accepted but not yet answered
//   push         a response is written into the instruction buffer
//   full         instruction buffer is full
// ---------------------------------------------------------------------------
module fetch_unit_checker #(
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             rst,
  input logic             resp_valid,
  input logic [CNT_W-1:0] outstanding,
  input logic             push,
  input logic             full
);

  // Memory must never answer a request that was not made.
  a_resp_has_request: assert property (
    @(posedge clk) disable iff (rst) resp_valid |-> (outstanding != {CNT_W{1'b0}})
  );

  // Credit accounting must keep the buffer from overflowing.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (rst) push |-> !full
  );

endmodule
